emu_ram_scan_ctrl: RTL and testbench



---
 rtl/emu_scan_pkg.sv | 23 ++
 rtl/emu_scan_fifo.sv | 48 ++++
 rtl/emu_ram_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_emu_ram_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/emu_scan_pkg.sv
// Shared types and helpers for the emulator RAM scan checkpoint engine.
package emu_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DUMP,
    S_DRAIN,
    S_LOAD,
    S_TAIL,
    S_UNSCAN,
    S_RELEASE
  } state_t;

  localparam logic DIR_DUMP = 1'b0;
  localparam logic DIR_LOAD = 1'b1;

  // Width of a counter that must reach n without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/emu_scan_fifo.sv
// Synchronous skid FIFO with occupancy count; push and pop together when full
// leaves occupancy unchanged.
module emu_scan_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_pop, w_push;

  assign w_pop  = pop && (r_cnt != '0);
  assign w_push = push && ((r_cnt != CW'(DEPTH)) || w_pop);
  assign rdata  = r_mem[r_rd];
  assign count  = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/emu_ram_scan_ctrl.sv
// Checkpoint engine: halts the DUT and dumps the RAM scan chain to a stream,
// or restores it from a stream, then releases halt.
module emu_ram_scan_ctrl
  import emu_scan_pkg::*;
#(
  parameter int WORDS      = 64,
  parameter int DW         = 64,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_dir,
  output logic          busy,
  output logic          done,
  output logic          halt,
  output logic          ram_scan,
  output logic          ram_dir,
  output logic [DW-1:0] ram_sdi,
  input  logic [DW-1:0] ram_sdo,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);
  localparam int CW  = cnt_w(WORDS);
  localparam int FCW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);

  state_t         r_state, w_next;
  logic           r_dir;
  logic [CW-1:0]  r_issued, r_loaded, r_received;
  logic [LAT-1:0] r_vld_pipe;
  logic [FCW-1:0] w_fifo_cnt;
  logic [DW-1:0]  w_fifo_rdata;
  logic           w_accept, w_issue, w_push, w_pop, w_load_hs;
  int             w_inflight;

  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < LAT; i++) w_inflight += int'(r_vld_pipe[i]);
  end

  // Credit check counts words still in the chain read latency so the FIFO
  // can always absorb everything already requested.
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_issue   = (r_state == S_DUMP) && (r_issued != WORDS_C) &&
                     ((int'(w_fifo_cnt) + w_inflight) < FIFO_DEPTH);
  assign w_push    = r_vld_pipe[LAT-1];
  assign w_pop     = out_valid && out_ready;
  assign w_load_hs = in_valid && in_ready;

  emu_scan_fifo #(
    .DW   (DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .wdata(ram_sdo),
    .pop  (w_pop),
    .rdata(w_fifo_rdata),
    .count(w_fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_DUMP;
      r_issued   <= '0;
      r_loaded   <= '0;
      r_received <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_state    <= w_next;
      r_vld_pipe <= (r_vld_pipe << 1) | LAT'(w_issue);
      if (w_accept) begin
        r_dir      <= cmd_dir;
        r_issued   <= '0;
        r_loaded   <= '0;
        r_received <= '0;
      end else begin
        if (w_issue)   r_issued   <= r_issued + 1'b1;
        if (w_load_hs) r_loaded   <= r_loaded + 1'b1;
        if (w_pop)     r_received <= r_received + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    halt      = 1'b1;
    in_ready  = 1'b0;
    ram_scan  = w_issue;
    ram_sdi   = '0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        halt      = 1'b0;
        if (cmd_valid) w_next = S_HALT;
      end
      S_HALT:  w_next = (r_dir == DIR_LOAD) ? S_LOAD : S_DUMP;
      S_DUMP:  if (r_issued == WORDS_C) w_next = S_DRAIN;
      S_DRAIN: if ((r_received == WORDS_C) && (r_vld_pipe == '0)) w_next = S_UNSCAN;
      S_LOAD: begin
        in_ready = (r_loaded != WORDS_C);
        ram_scan = in_valid && (r_loaded != WORDS_C);
        ram_sdi  = in_data;
        if (in_valid && (r_loaded == WORDS_C - 1'b1)) w_next = S_TAIL;
      end
      // Commit cycle: one extra shift with zero data latches the loaded image.
      S_TAIL: begin
        ram_scan = 1'b1;
        w_next   = S_UNSCAN;
      end
      S_UNSCAN: w_next = S_RELEASE;
      S_RELEASE: begin
        halt   = 1'b0;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ram_dir   = halt && r_dir;
  assign out_valid = (w_fifo_cnt != '0);
  assign out_data  = out_valid ? w_fifo_rdata : '0;

endmodule

// File: tb/tb_emu_ram_scan_ctrl.sv
// Bench for emu_ram_scan_ctrl: behavioural scan chain, table of sessions with
// queue scoreboards, plus reset-mid-dump and held-command sequences.
module tb_emu_ram_scan_ctrl;
  localparam int WORDS = 64;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int FD    = 4;
  localparam int MAXC  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_dir = 1'b0, out_ready = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic cmd_ready, busy, done, halt, ram_scan, ram_dir, out_valid, in_ready;
  logic [DW-1:0] ram_sdi, ram_sdo, out_data;

  always #5 clk = ~clk;

  emu_ram_scan_ctrl #(.WORDS(WORDS), .DW(DW), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .busy(busy), .done(done), .halt(halt),
    .ram_scan(ram_scan), .ram_dir(ram_dir), .ram_sdi(ram_sdi), .ram_sdo(ram_sdo),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  // Chain model: advances on ram_scan, read data appears LAT cycles after the
  // enable, position rewinds whenever halt is low.
  logic [DW-1:0] chain  [WORDS];
  logic [DW-1:0] bd_buf [WORDS];
  logic [DW-1:0] sdo_p  [LAT];
  logic          bd_load = 1'b0;
  int            ci = 0, m_tail = 0;

  always @(posedge clk) begin
    sdo_p[0] <= (ci < WORDS) ? chain[ci] : '0;
    for (int i = 1; i < LAT; i++) sdo_p[i] <= sdo_p[i-1];
    if (bd_load) begin
      for (int k = 0; k < WORDS; k++) chain[k] <= bd_buf[k];
    end else if (!halt) begin
      ci     <= 0;
      m_tail <= 0;
    end else if (ram_scan) begin
      if (!ram_dir) ci <= ci + 1;
      else if (ci < WORDS) begin
        chain[ci] <= ram_sdi;
        ci        <= ci + 1;
      end else m_tail <= m_tail + 1;
    end
  end
  assign ram_sdo = sdo_p[LAT-1];

  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] slot [10][WORDS];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rexp_q[$];
  bit h_tr [MAXC+1];
  bit s_tr [MAXC+1];

  typedef struct {
    bit dir;
    int bd;        // image slot backdoor-loaded into the chain first, -1 none
    int rdy;       // out_ready duty in percent
    int gap;       // restore: offer a word every gap cycles
    int src;       // dump: expected image slot / restore: data slot
    int dst;       // dump: slot to save the dumped beats into, -1 none
    int exp_beats;
    bit exp_pause;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input int k);
    case (i)
      0:       return 64'(k) * 64'h0101_0101_0101_0101;
      1:       return ~(64'(k) * 64'h0001_0003_0005_0007);
      2:       return 64'hDEAD_BEEF_0000_0000 | (64'(k) << 8) | 64'(63 - k);
      3:       return {$urandom(), $urandom()};
      4:       return 64'hA5A5_0000_0000_0000 + 64'(k);
      default: return 64'hFFFF_0000_FFFF_0000 ^ 64'(k);
    endcase
  endfunction

  task automatic backdoor(input int i);
    for (int k = 0; k < WORDS; k++) bd_buf[k] = slot[i][k];
    bd_load = 1'b1;
    @(posedge clk); #1;
    bd_load = 1'b0;
  endtask

  task automatic accept(input bit dir, input bit hold);
    int t = 0;
    cmd_dir   = dir;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = hold;
  endtask

  // Runs one session from the cycle after accept to the done pulse.
  task automatic run_body(input vec_t v, input bit hold);
    int cyc = 0, beats = 0, sent = 0, accepts = 0, pauses = 0, stray = 0;
    int first_scan = -1, last_scan = -1, done_cyc = -1, tail_cyc = -1, bad_img = 0;
    bit hs = 0, pv = 0, pr = 0;
    logic [DW-1:0] pd = '0;
    exp_q.delete();
    rexp_q.delete();
    in_valid = 1'b0;
    if (!v.dir) for (int k = 0; k < WORDS; k++) exp_q.push_back(slot[v.src][k]);
    while (cyc < MAXC && done_cyc < 0) begin
      cyc++;
      if (hs) in_valid = 1'b0;
      hs = 0;
      if (v.dir) begin
        out_ready = 1'b0;
        if (!in_valid && sent < WORDS && (cyc % v.gap) == 0) begin
          in_valid = 1'b1;
          in_data  = slot[v.src][sent];
        end
      end else begin
        out_ready = ($urandom_range(99, 0) < v.rdy);
        in_valid  = 1'b1;
        in_data   = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      @(negedge clk);
      h_tr[cyc] = halt;
      s_tr[cyc] = ram_scan;
      if (hold && cmd_ready) accepts++;
      if (dut.u_fifo.count > FD) chk("fifo_occupancy", 64'(dut.u_fifo.count), 64'(FD));
      if (!v.dir && (in_ready || ram_sdi != '0)) stray++;
      if (out_valid && pv && !pr) chk("out_data_stable", out_data, pd);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("dump_extra_beat", 64'(beats), 64'(WORDS));
        else chk($sformatf("dump_word_%0d", beats), out_data, exp_q.pop_front());
        if (v.dst >= 0 && beats < WORDS) slot[v.dst][beats] = out_data;
        beats++;
      end
      if (in_valid && in_ready) begin
        rexp_q.push_back(in_data);
        sent++;
        hs = 1;
      end
      if (ram_scan && ram_dir) begin
        if (in_ready) begin
          if (rexp_q.size() == 0) chk("restore_unexpected_scan", 64'(cyc), 64'(0));
          else chk($sformatf("restore_sdi_%0d", sent - 1), ram_sdi, rexp_q.pop_front());
        end else begin
          chk("tail_sdi_zero", ram_sdi, 64'd0);
          tail_cyc = cyc;
        end
      end
      if (ram_scan) begin
        if (first_scan < 0) first_scan = cyc;
        last_scan = cyc;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (done) begin
        done_cyc = cyc;
        chk("done_halt_low", 64'(halt), 64'd0);
        if (v.dir) begin
          chk("restore_words_in_chain", 64'(ci), 64'(WORDS));
          chk("restore_tail_count", 64'(m_tail), 64'd1);
          for (int k = 0; k < WORDS; k++) if (chain[k] !== slot[v.src][k]) bad_img++;
          chk("restore_image_bad_words", 64'(bad_img), 64'd0);
        end
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("session_done_seen", 64'(done_cyc > 0), 64'd1);
    chk("halt_after_accept", 64'(h_tr[1]), 64'd1);
    if (hold) chk("no_accept_while_busy", 64'(accepts), 64'd0);
    if (!v.dir) begin
      chk("dump_first_scan_cycle", 64'(first_scan), 64'd2);
      chk("dump_beats", 64'(beats), 64'(v.exp_beats));
      chk("dump_stray_in", 64'(stray), 64'd0);
      if (first_scan > 0)
        for (int c = first_scan; c <= last_scan; c++) if (!s_tr[c]) pauses++;
      chk("dump_pauses_seen", 64'(pauses > 0), 64'(v.exp_pause));
    end else if (done_cyc > 2) begin
      chk("tail_two_before_done", 64'(tail_cyc), 64'(done_cyc - 2));
      chk("unscan_halt", 64'(h_tr[done_cyc-1]), 64'd1);
      chk("unscan_scan_low", 64'(s_tr[done_cyc-1]), 64'd0);
    end
  endtask

  task automatic run_row(input vec_t v);
    if (v.bd >= 0) backdoor(v.bd);
    accept(v.dir, 1'b0);
    run_body(v, 1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_others"}, 64'({busy, done, halt, ram_scan, ram_dir, out_valid, in_ready}), 64'd0);
    chk({tag, "_ram_sdi"}, ram_sdi, 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
  endtask

  initial begin
    int beats, t;
    vec_t v;
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < WORDS; k++) slot[i][k] = mk(i, k);

    vt.push_back('{0, 0, 100, 1, 0, -1, 64, 1'b0});
    vt.push_back('{0, 0, 30, 1, 0, -1, 64, 1'b1});
    vt.push_back('{1, 5, 100, 3, 4, -1, 0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      vt.push_back('{0, i, 100, 1, i, 6 + i, 64, 1'b0});
      vt.push_back('{1, 5, 100, 2, 6 + i, -1, 0, 1'b0});
      vt.push_back('{0, -1, 45, 1, 6 + i, -1, 64, 1'b1});
    end

    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[i]) run_row(vt[i]);

    // Reset pulse after 20 dumped words; a fresh dump must start from word 0.
    backdoor(0);
    accept(1'b0, 1'b0);
    out_ready = 1'b1;
    beats = 0; t = 0;
    while (beats < 20 && t < 500) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        chk("pre_reset_word", out_data, slot[0][beats]);
        beats++;
      end
      t++;
    end
    chk("pre_reset_beats", 64'(beats), 64'd20);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    run_row('{0, -1, 100, 1, 0, -1, 64, 1'b0});

    // cmd_valid held through a restore: the next accept lands the cycle after done.
    backdoor(5);
    v = '{1, -1, 100, 1, 4, -1, 0, 1'b0};
    accept(1'b1, 1'b1);
    run_body(v, 1'b1);
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("accept_right_after_done", 64'({cmd_ready, busy}), 64'b10);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    run_body(v, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
